// File: rtl/bsg_mac_pipelined.sv
// bsg_mac_pipelined: two-stage pipelined multiply-accumulate, s = a*b + addend.
// Stage 1 registers the exact 2W product, stage 2 adds the addend (c_i or the
// previous result in chain mode) and produces s_o / c_o with valid/ready flow.
// Optional feature: define BSG_MAC_SAT_EN to saturate s_o on overflow instead
// of wrapping modulo 2^(2W).
module bsg_mac_pipelined #(
  parameter int unsigned width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [width_p-1:0]     a_i,
  input  logic [width_p-1:0]     b_i,
  input  logic [2*width_p-1:0]   c_i,
  input  logic                   signed_i,
  input  logic                   acc_i,
  output logic                   v_o,
  input  logic                   ready_i,
  output logic [2*width_p-1:0]   s_o,
  output logic                   c_o
);

  localparam int unsigned ResW = 2 * width_p;

  // Stage 1 state
  logic            v1_q;
  logic [ResW-1:0] p_q;
  logic [ResW-1:0] c1_q;
  logic            signed1_q;
  logic            acc1_q;

  // Stage 2 state
  logic            v2_q;
  logic [ResW-1:0] s_q;
  logic            co_q;

  logic            en1;
  logic            en2;
  logic [ResW-1:0] a_ext;
  logic [ResW-1:0] b_ext;
  logic [ResW-1:0] prod;
  logic [ResW-1:0] addend;
  logic [ResW:0]   sum_ext;
  logic            ovf;
  logic [ResW-1:0] s_d;

  // Stage enables: stage 2 advances when empty or drained; stage 1 follows.
  always_comb begin
    en2     = ~v2_q | ready_i;
    en1     = ~v1_q | en2;
    ready_o = en1;
  end

  // Exact product: extend both operands to 2W so the truncated product is exact.
  always_comb begin
    a_ext = signed_i ? {{width_p{a_i[width_p-1]}}, a_i} : {{width_p{1'b0}}, a_i};
    b_ext = signed_i ? {{width_p{b_i[width_p-1]}}, b_i} : {{width_p{1'b0}}, b_i};
    prod  = a_ext * b_ext;
  end

  // Stage 2 add and overflow detection; chain mode reads the live s_o register.
  always_comb begin
    addend  = acc1_q ? s_q : c1_q;
    sum_ext = {1'b0, p_q} + {1'b0, addend};
    if (signed1_q) begin
      ovf = (p_q[ResW-1] == addend[ResW-1]) && (sum_ext[ResW-1] != p_q[ResW-1]);
    end else begin
      ovf = sum_ext[ResW];
    end
    s_d = sum_ext[ResW-1:0];
`ifdef BSG_MAC_SAT_EN
    if (ovf) begin
      if (signed1_q) begin
        // Both operands share a sign on overflow; that sign picks the rail.
        s_d = p_q[ResW-1] ? {1'b1, {(ResW-1){1'b0}}} : {1'b0, {(ResW-1){1'b1}}};
      end else begin
        s_d = {ResW{1'b1}};
      end
    end
`endif
  end

  // Stage 1 registers: capture operands on input handshake.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v1_q      <= 1'b0;
      p_q       <= '0;
      c1_q      <= '0;
      signed1_q <= 1'b0;
      acc1_q    <= 1'b0;
    end else if (en1) begin
      v1_q <= v_i;
      if (v_i) begin
        p_q       <= prod;
        c1_q      <= c_i;
        signed1_q <= signed_i;
        acc1_q    <= acc_i;
      end
    end
  end

  // Stage 2 registers: result only loads when stage 1 holds a transaction.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v2_q <= 1'b0;
      s_q  <= '0;
      co_q <= 1'b0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s_q  <= s_d;
        co_q <= ovf;
      end
    end
  end

  assign v_o = v2_q;
  assign s_o = s_q;
  assign c_o = co_q;

endmodule

// File: tb/tb_bsg_mac_pipelined.sv
// Self-checking bench for bsg_mac_pipelined at width_p = 8 (16-bit results).
module tb_bsg_mac_pipelined;

  localparam int W = 8;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
    logic        sg;
    logic        acc;
    logic [15:0] s;
    logic        co;
  } vec_t;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    int          idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        v_in = 1'b0;
  logic        ready_out;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic [15:0] c_in = '0;
  logic        signed_in = 1'b0;
  logic        acc_in = 1'b0;
  logic        v_out;
  logic        ready_in = 1'b1;
  logic [15:0] s_out;
  logic        co_out;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic [15:0] last_s = '0;
  int   hs_cyc[10];
  int   out_cyc[10];
  vec_t tbl[10];

  bsg_mac_pipelined #(.width_p(W)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .v_i       (v_in),
    .ready_o   (ready_out),
    .a_i       (a_in),
    .b_i       (b_in),
    .c_i       (c_in),
    .signed_i  (signed_in),
    .acc_i     (acc_in),
    .v_o       (v_out),
    .ready_i   (ready_in),
    .s_o       (s_out),
    .c_o       (co_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model using wide integer arithmetic; returns {overflow, s}.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [15:0] c, input logic sg,
                                        input logic acc, input logic [15:0] last);
    longint      pa, pb, ad, sum;
    logic [15:0] add, s;
    logic [63:0] sv;
    logic        ov;
    add = acc ? last : c;
    if (sg) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      ad = longint'($signed(add));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
      ad = longint'(add);
    end
    sum = pa * pb + ad;
    ov  = sg ? (sum > 32767 || sum < -32768) : (sum > 65535);
    sv  = sum;
    s   = sv[15:0];
`ifdef BSG_MAC_SAT_EN
    if (ov) s = sg ? ((sum > 0) ? 16'h7FFF : 16'h8000) : 16'hFFFF;
`endif
    return {ov, s};
  endfunction

  // Drive one transaction (called right after a negedge); push expectation on handshake.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c,
                      input logic sg, input logic acc, input logic [15:0] es,
                      input logic eco, input int idx);
    bit done = 1'b0;
    a_in = a; b_in = b; c_in = c; signed_in = sg; acc_in = acc; v_in = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      #1;
      if (ready_out) begin
        sb.push_back('{s: es, co: eco, idx: idx});
        last_s = es;
        if (idx >= 0) hs_cyc[idx] = cyc;
        done = 1'b1;
      end
      @(negedge clk);
    end
    v_in = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got ready_o=0, expected acceptance within 200 cycles");
    end
  endtask

  task automatic send_model(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c,
                            input logic sg, input logic acc);
    logic [16:0] r;
    r = model(a, b, c, sg, acc, last_s);
    send(a, b, c, sg, acc, r[15:0], r[16], -1);
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: a result is consumed when v_o & ready_i before the next edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset_n && v_out && ready_in) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got s_o=0x%0h, expected no result", s_out);
      end else begin
        e = sb.pop_front();
        check("s_o", 32'(s_out), 32'(e.s));
        check("c_o", 32'(co_out), 32'(e.co));
        if (e.idx >= 0) out_cyc[e.idx] = cyc;
      end
    end
  end

  initial begin
    for (int i = 0; i < 10; i++) begin
      hs_cyc[i]  = 0;
      out_cyc[i] = -100;
    end
    //         a      b      c         sg    acc   s         co
    tbl[0] = '{8'h03, 8'h04, 16'h0005, 1'b0, 1'b0, 16'h0011, 1'b0};
    tbl[1] = '{8'hFF, 8'h02, 16'h0000, 1'b1, 1'b0, 16'hFFFE, 1'b0};
    tbl[2] = '{8'hFF, 8'h02, 16'h0000, 1'b0, 1'b0, 16'h01FE, 1'b0};
    tbl[3] = '{8'h01, 8'h00, 16'd10,   1'b0, 1'b0, 16'd10,   1'b0};
    tbl[4] = '{8'h02, 8'h03, 16'h0000, 1'b0, 1'b1, 16'd16,   1'b0};
    tbl[5] = '{8'h01, 8'h04, 16'h0000, 1'b0, 1'b1, 16'd20,   1'b0};
`ifdef BSG_MAC_SAT_EN
    tbl[6] = '{8'hFF, 8'hFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b1};
    tbl[7] = '{8'h80, 8'h80, 16'h7FFF, 1'b1, 1'b0, 16'h7FFF, 1'b1};
    tbl[8] = '{8'h80, 8'h7F, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b1};
    tbl[9] = '{8'h01, 8'h01, 16'h0000, 1'b1, 1'b1, 16'h8001, 1'b0};
`else
    tbl[6] = '{8'hFF, 8'hFF, 16'hFFFF, 1'b0, 1'b0, 16'hFE00, 1'b1};
    tbl[7] = '{8'h80, 8'h80, 16'h7FFF, 1'b1, 1'b0, 16'hBFFF, 1'b1};
    tbl[8] = '{8'h80, 8'h7F, 16'h8000, 1'b1, 1'b0, 16'h4080, 1'b1};
    tbl[9] = '{8'h01, 8'h01, 16'h0000, 1'b1, 1'b1, 16'h4081, 1'b0};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_v_o", 32'(v_out), 32'd0);
    check("reset_s_o", 32'(s_out), 32'd0);
    check("reset_c_o", 32'(co_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_ready_o", 32'(ready_out), 32'd1);
    @(negedge clk);

    // Table vectors, back-to-back
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sg, tbl[i].acc, tbl[i].s, tbl[i].co, i);
    end
    drain();
    @(negedge clk);
    #3;
    check("idle_v_o", 32'(v_out), 32'd0);
    check("idle_s_hold", 32'(s_out), 32'(last_s));
    check("latency", 32'(out_cyc[0] - hs_cyc[0]), 32'd2);
    check("chain_gap_1", 32'(out_cyc[4] - out_cyc[3]), 32'd1);
    check("chain_gap_2", 32'(out_cyc[5] - out_cyc[4]), 32'd1);
    @(negedge clk);

    // Back-pressure: 5 transactions while ready_i is held low for 4 cycles
    ready_in = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          send_model(8'($urandom), 8'($urandom), 16'($urandom),
                     1'($urandom_range(0, 1)), (i == 2 || i == 3) ? 1'b1 : 1'b0);
        end
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        check("bp_ready_low", 32'(ready_out), 32'd0);
        check("bp_v_o_held", 32'(v_out), 32'd1);
        @(negedge clk);
        ready_in = 1'b1;
      end
    join
    drain();
    @(negedge clk);

    // Asynchronous reset with 2 transactions in flight
    ready_in = 1'b0;
    send_model(8'h11, 8'h22, 16'h0033, 1'b0, 1'b0);
    send_model(8'h05, 8'h06, 16'h0007, 1'b0, 1'b1);
    #1;
    check("pre_reset_v_o", 32'(v_out), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_v_o", 32'(v_out), 32'd0);
    check("async_reset_s_o", 32'(s_out), 32'd0);
    check("async_reset_c_o", 32'(co_out), 32'd0);
    sb.delete();
    last_s = '0;
    @(negedge clk);
    ready_in = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_reset_ready_o", 32'(ready_out), 32'd1);
    @(negedge clk);
    send(8'h02, 8'h02, 16'h0000, 1'b0, 1'b1, 16'd4, 1'b0, -1);
    drain();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
